eth_tx_frame_feeder: RTL and testbench

- Store-and-forward frame buffer that drives the Ethernet MAC transmit-FIFO interface (fifodata/fifoavail/fifoeof/fifoempty, read by the MAC via macread) from a byte-wide valid/ready stream.
- Sits between the UDP/ringbus packet builder and the MAC, in the 125 MHz TX clock domain.
- Advertises a frame only once it is fully buffered, so the MAC never underruns mid-frame.

---
 rtl/eth_tx_frame_feeder_if.sv | 43 ++++
 rtl/eth_tx_frame_feeder.sv | 228 ++++++++++++++++++++++
 tb/tb_eth_tx_frame_feeder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_frame_feeder_if.sv
// -----------------------------------------------------------------------------
// eth_tx_frame_feeder_if
//
// Bundles the two data paths of the TX frame feeder:
//   - byte stream from the packet builder : i_s_tdata, i_s_tvalid, i_s_tlast,
//                                           o_s_tready
//   - MAC transmit-FIFO side              : o_tx_fifodata, o_tx_fifoeof,
//                                           o_tx_fifoavail, o_tx_fifoempty,
//                                           i_tx_macread, i_tx_done
// Signal names keep the feeder's point of view (i_ = into the feeder,
// o_ = out of the feeder).
//
// Modports:
//   slave  - the feeder itself
//   master - the environment (packet builder + MAC)
// -----------------------------------------------------------------------------
interface eth_tx_frame_feeder_if;

    logic [7:0] i_s_tdata;
    logic       i_s_tvalid;
    logic       i_s_tlast;
    logic       o_s_tready;

    logic [7:0] o_tx_fifodata;
    logic       o_tx_fifoeof;
    logic       o_tx_fifoavail;
    logic       o_tx_fifoempty;
    logic       i_tx_macread;
    logic       i_tx_done;

    modport slave (
        input  i_s_tdata, i_s_tvalid, i_s_tlast, i_tx_macread, i_tx_done,
        output o_s_tready, o_tx_fifodata, o_tx_fifoeof, o_tx_fifoavail,
               o_tx_fifoempty
    );

    modport master (
        output i_s_tdata, i_s_tvalid, i_s_tlast, i_tx_macread, i_tx_done,
        input  o_s_tready, o_tx_fifodata, o_tx_fifoeof, o_tx_fifoavail,
               o_tx_fifoempty
    );

endinterface

// File: rtl/eth_tx_frame_feeder.sv
// -----------------------------------------------------------------------------
// eth_tx_frame_feeder
//
// Store-and-forward frame buffer between the packet builder (byte-wide
// valid/ready stream) and the Ethernet MAC transmit-FIFO interface. A frame is
// advertised to the MAC (o_tx_fifoavail) only once its last byte is buffered,
// so the MAC never underruns inside a frame. Frames longer than P_MAX_FRAME are
// cut at P_MAX_FRAME bytes (eof forced on the last kept byte) and the rest of
// the frame is swallowed.
//
// Parameters:
//   P_DEPTH     - buffer depth in bytes (power of 2, >= 64)
//   P_MAX_FRAME - maximum stored bytes per frame (<= P_DEPTH)
//
// Ports:
//   i_tx_clk125    - 125 MHz TX clock
//   i_srst_n       - synchronous active-low reset
//   bus            - eth_tx_frame_feeder_if.slave (stream in, MAC FIFO out)
//   o_trunc        - one-cycle pulse: a frame was truncated
//   o_underrun     - one-cycle pulse: MAC read while the buffer was empty
//   o_frames_sent  - saturating count of i_tx_done pulses (stats build)
//   o_frames_trunc - saturating count of truncated frames (stats build)
//
// Build option:
//   ETH_TX_FEEDER_STATS_EN - when defined, builds the two 16-bit statistics
//   counters; otherwise both outputs are tied to 0 and i_tx_done is ignored.
// -----------------------------------------------------------------------------
module eth_tx_frame_feeder #(
    parameter int P_DEPTH     = 2048,
    parameter int P_MAX_FRAME = 1518
) (
    input  logic                     i_tx_clk125,
    input  logic                     i_srst_n,
    eth_tx_frame_feeder_if.slave     bus,
    output logic                     o_trunc,
    output logic                     o_underrun,
    output logic [15:0]              o_frames_sent,
    output logic [15:0]              o_frames_trunc
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int LW = $clog2(P_MAX_FRAME + 1);

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_DISCARD = 1'b1
    } wr_state_e;

    // Each entry is {eof, byte}.
    logic [8:0]    mem [P_DEPTH];

    wr_state_e     state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   frame_cnt_q, frame_cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic          tready_q, tready_d;
    logic          avail_q, avail_d;
    logic          empty_q, empty_d;
    logic          trunc_q, trunc_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    data_q;
    logic          eof_q;

    logic [AW:0]   used, used_d;
    logic          wr_fire;
    logic          rd_en;
    logic          at_max;
    logic          commit;
    logic          eof_read;
    logic          mem_we;
    logic [8:0]    mem_wdata;
    logic [8:0]    rd_word;

    // Pointers carry a wrap bit, so modular subtraction yields 0..P_DEPTH.
    assign used    = wr_ptr_q - rd_ptr_q;
    assign wr_fire = bus.i_s_tvalid & tready_q;
    assign rd_en   = bus.i_tx_macread & (used != '0);
    assign at_max  = (len_q == LW'(P_MAX_FRAME - 1));
    assign rd_word = mem[rd_ptr_q[AW-1:0]];

    // -------------------------------------------------------------------------
    // Next-state logic: write FSM, pointers, frame count, registered flags
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        frame_cnt_d = frame_cnt_q;
        commit      = 1'b0;
        trunc_d     = 1'b0;
        mem_we      = 1'b0;
        // eof is forced on the P_MAX_FRAME-th byte so a cut frame still ends.
        mem_wdata   = {bus.i_s_tlast | at_max, bus.i_s_tdata};

        unique case (state_q)
            ST_ACCEPT: begin
                if (wr_fire) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (bus.i_s_tlast) begin
                        commit = 1'b1;
                        len_d  = '0;
                    end else if (at_max) begin
                        commit  = 1'b1;
                        trunc_d = 1'b1;
                        len_d   = '0;
                        state_d = ST_DISCARD;
                    end else begin
                        len_d = len_q + 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (wr_fire && bus.i_s_tlast) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase

        eof_read = rd_en & rd_word[8];
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // A commit and an eof read in the same cycle cancel out.
        unique case ({commit, eof_read})
            2'b10:   frame_cnt_d = frame_cnt_q + 1'b1;
            2'b01:   frame_cnt_d = frame_cnt_q - 1'b1;
            default: frame_cnt_d = frame_cnt_q;
        endcase

        used_d     = wr_ptr_d - rd_ptr_d;
        avail_d    = (frame_cnt_d != '0);
        empty_d    = (used_d == '0);
        // Discarded bytes never touch the buffer, so DISCARD always accepts.
        tready_d   = (state_d == ST_DISCARD) || (used_d != (AW+1)'(P_DEPTH));
        underrun_d = bus.i_tx_macread & (used == '0);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge i_tx_clk125) begin
        if (!i_srst_n) begin
            state_q     <= ST_ACCEPT;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            len_q       <= '0;
            tready_q    <= 1'b0;
            avail_q     <= 1'b0;
            empty_q     <= 1'b1;
            trunc_q     <= 1'b0;
            underrun_q  <= 1'b0;
            data_q      <= '0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            len_q       <= len_d;
            tready_q    <= tready_d;
            avail_q     <= avail_d;
            empty_q     <= empty_d;
            trunc_q     <= trunc_d;
            underrun_q  <= underrun_d;
            // Read data holds between reads and on underrun.
            if (rd_en) begin
                {eof_q, data_q} <= rd_word;
            end
        end
    end

    // NOTE: the buffer storage has no reset; stale entries are unreachable
    // because the pointers are reset, and a resettable array cannot map to RAM.
    always_ff @(posedge i_tx_clk125) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= mem_wdata;
        end
    end

    assign bus.o_s_tready     = tready_q;
    assign bus.o_tx_fifodata  = data_q;
    assign bus.o_tx_fifoeof   = eof_q;
    assign bus.o_tx_fifoavail = avail_q;
    assign bus.o_tx_fifoempty = empty_q;
    assign o_trunc            = trunc_q;
    assign o_underrun         = underrun_q;

    // -------------------------------------------------------------------------
    // Optional statistics
    // -------------------------------------------------------------------------
`ifdef ETH_TX_FEEDER_STATS_EN
    logic [15:0] sent_cnt_q;
    logic [15:0] trunc_cnt_q;

    always_ff @(posedge i_tx_clk125) begin
        if (!i_srst_n) begin
            sent_cnt_q  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            if (bus.i_tx_done && (sent_cnt_q != 16'hFFFF)) begin
                sent_cnt_q <= sent_cnt_q + 1'b1;
            end
            if (trunc_d && (trunc_cnt_q != 16'hFFFF)) begin
                trunc_cnt_q <= trunc_cnt_q + 1'b1;
            end
        end
    end

    assign o_frames_sent  = sent_cnt_q;
    assign o_frames_trunc = trunc_cnt_q;
`else
    logic unused_tx_done;
    assign unused_tx_done = bus.i_tx_done;
    assign o_frames_sent  = '0;
    assign o_frames_trunc = '0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_feeder.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_frame_feeder
//
// Directed bench for eth_tx_frame_feeder, built with P_DEPTH = 64 and
// P_MAX_FRAME = 64 so that fill-up and truncation are reached with short
// frames. Inputs change 1 ns after the rising edge; outputs are sampled at the
// same point, i.e. they show the result of the edge just passed.
// -----------------------------------------------------------------------------
module tb_eth_tx_frame_feeder;

`ifdef ETH_TX_FEEDER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        trunc;
    logic        underrun;
    logic [15:0] frames_sent;
    logic [15:0] frames_trunc;

    eth_tx_frame_feeder_if bus ();

    eth_tx_frame_feeder #(
        .P_DEPTH     (64),
        .P_MAX_FRAME (64)
    ) dut (
        .i_tx_clk125    (clk),
        .i_srst_n       (rst_n),
        .bus            (bus),
        .o_trunc        (trunc),
        .o_underrun     (underrun),
        .o_frames_sent  (frames_sent),
        .o_frames_trunc (frames_trunc)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int trunc_seen = 0;
    logic [8:0] exp_q[$];

    always @(negedge clk) begin
        if (trunc) trunc_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until the registered tready takes it.
    task automatic push_byte(input logic [7:0] d, input logic last);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        bus.i_s_tdata  = d;
        bus.i_s_tvalid = 1'b1;
        bus.i_s_tlast  = last;
        while (!acc && n < 200) begin
            acc = bus.o_s_tready;
            tick();
            n++;
        end
        bus.i_s_tvalid = 1'b0;
        bus.i_s_tlast  = 1'b0;
        check("push_accepted", 32'(acc), 1);
    endtask

    task automatic send_frame(input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            push_byte(base + 8'(i), i == len - 1);
            exp_q.push_back({i == len - 1, base + 8'(i)});
        end
    endtask

    // Hold macread for n cycles and check each byte one cycle after its read.
    task automatic read_bytes(input int n);
        logic [8:0] e;
        bus.i_tx_macread = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            e = exp_q.pop_front();
            check("rd_data", bus.o_tx_fifodata, e[7:0]);
            check("rd_eof", bus.o_tx_fifoeof, e[8]);
        end
        bus.i_tx_macread = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] e;
        int         trunc_base;

        rst_n            = 1'b0;
        bus.i_s_tdata    = '0;
        bus.i_s_tvalid   = 1'b0;
        bus.i_s_tlast    = 1'b0;
        bus.i_tx_macread = 1'b0;
        bus.i_tx_done    = 1'b0;
        tick();
        tick();

        // ---- reset state and underrun ----
        check("rst_empty", bus.o_tx_fifoempty, 1);
        check("rst_avail", bus.o_tx_fifoavail, 0);
        check("rst_tready", bus.o_s_tready, 0);
        check("rst_data", bus.o_tx_fifodata, 0);
        check("rst_underrun", underrun, 0);
        rst_n = 1'b1;
        check("tready_first_cycle", bus.o_s_tready, 0);
        tick();
        check("tready_second_cycle", bus.o_s_tready, 1);
        bus.i_tx_macread = 1'b1;
        tick();
        bus.i_tx_macread = 1'b0;
        check("underrun_pulse", underrun, 1);
        check("underrun_data_hold", bus.o_tx_fifodata, 0);
        tick();
        check("underrun_clear", underrun, 0);
        check("underrun_empty", bus.o_tx_fifoempty, 1);

        // ---- 64-byte frame 0x00..0x3F ----
        for (int i = 0; i < 64; i++) begin
            push_byte(8'(i), i == 63);
            exp_q.push_back({i == 63, 8'(i)});
            if (i < 63) check("avail_before_tlast", bus.o_tx_fifoavail, 0);
        end
        check("avail_after_tlast", bus.o_tx_fifoavail, 1);
        check("not_empty_after_write", bus.o_tx_fifoempty, 0);
        read_bytes(64);
        check("avail_after_read", bus.o_tx_fifoavail, 0);
        check("empty_after_read", bus.o_tx_fifoempty, 1);
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        check("frames_sent_one", frames_sent, STATS ? 1 : 0);

        // ---- fill to 64 bytes, stall, drain 8, resume ----
        send_frame(8'h40, 40);
        for (int i = 0; i < 24; i++) begin
            push_byte(8'h80 + 8'(i), 1'b0);
            exp_q.push_back({1'b0, 8'h80 + 8'(i)});
        end
        check("full_tready_low", bus.o_s_tready, 0);
        bus.i_s_tdata  = 8'h98;
        bus.i_s_tvalid = 1'b1;
        tick();
        bus.i_s_tvalid = 1'b0;
        check("full_tready_hold", bus.o_s_tready, 0);
        read_bytes(8);
        check("resume_tready", bus.o_s_tready, 1);
        for (int i = 24; i < 30; i++) begin
            push_byte(8'h80 + 8'(i), i == 29);
            exp_q.push_back({i == 29, 8'h80 + 8'(i)});
        end
        check("two_frames_avail", bus.o_tx_fifoavail, 1);
        read_bytes(62);
        check("fill_drain_avail", bus.o_tx_fifoavail, 0);
        check("fill_drain_empty", bus.o_tx_fifoempty, 1);

        // ---- 100-byte frame truncated at 64 ----
        trunc_base = trunc_seen;
        for (int i = 0; i < 100; i++) begin
            push_byte(8'(i), i == 99);
            if (i < 64) exp_q.push_back({i == 63, 8'(i)});
            if (i == 63) check("trunc_pulse", trunc, 1);
        end
        check("trunc_once", 32'(trunc_seen - trunc_base), 1);
        check("trunc_avail", bus.o_tx_fifoavail, 1);
        check("trunc_full_tready", bus.o_s_tready, 0);
        check("frames_trunc_one", frames_trunc, STATS ? 1 : 0);
        read_bytes(64);
        check("trunc_drain_empty", bus.o_tx_fifoempty, 1);
        send_frame(8'hA0, 10);
        read_bytes(10);
        check("post_trunc_avail", bus.o_tx_fifoavail, 0);

        // ---- commit of B coincides with eof read of A ----
        send_frame(8'hC0, 4);
        push_byte(8'hD0, 1'b0);
        push_byte(8'hD1, 1'b0);
        bus.i_tx_macread = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            check("coinc_rd_data", bus.o_tx_fifodata, e[7:0]);
        end
        check("coinc_avail_before", bus.o_tx_fifoavail, 1);
        check("coinc_tready", bus.o_s_tready, 1);
        bus.i_s_tdata  = 8'hD2;
        bus.i_s_tvalid = 1'b1;
        bus.i_s_tlast  = 1'b1;
        tick();
        bus.i_s_tvalid   = 1'b0;
        bus.i_s_tlast    = 1'b0;
        bus.i_tx_macread = 1'b0;
        e = exp_q.pop_front();
        check("coinc_eof_data", bus.o_tx_fifodata, e[7:0]);
        check("coinc_eof_flag", bus.o_tx_fifoeof, 1);
        check("coinc_avail_after", bus.o_tx_fifoavail, 1);
        exp_q.push_back({1'b0, 8'hD0});
        exp_q.push_back({1'b0, 8'hD1});
        exp_q.push_back({1'b1, 8'hD2});
        tick();
        check("coinc_avail_idle", bus.o_tx_fifoavail, 1);
        read_bytes(3);
        check("coinc_final_avail", bus.o_tx_fifoavail, 0);
        check("coinc_final_empty", bus.o_tx_fifoempty, 1);

        // ---- reset in the middle of reading a frame ----
        send_frame(8'h00, 60);
        read_bytes(30);
        bus.i_tx_macread = 1'b1;
        rst_n = 1'b0;
        tick();
        bus.i_tx_macread = 1'b0;
        check("midrst_tready", bus.o_s_tready, 0);
        check("midrst_data", bus.o_tx_fifodata, 0);
        check("midrst_eof", bus.o_tx_fifoeof, 0);
        check("midrst_avail", bus.o_tx_fifoavail, 0);
        check("midrst_empty", bus.o_tx_fifoempty, 1);
        check("midrst_trunc", trunc, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_frames_sent", frames_sent, 0);
        check("midrst_frames_trunc", frames_trunc, 0);
        exp_q.delete();
        rst_n = 1'b1;
        send_frame(8'hE0, 10);
        check("midrst_new_avail", bus.o_tx_fifoavail, 1);
        read_bytes(10);
        check("midrst_new_empty", bus.o_tx_fifoempty, 1);
        for (int i = 0; i < 3; i++) begin
            bus.i_tx_done = 1'b1;
            tick();
            bus.i_tx_done = 1'b0;
            tick();
        end
        check("frames_sent_three", frames_sent, STATS ? 3 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
